cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- NUM_PORTS, 2, number of cache requesters; port 0 is the icache, port 1 is the dcache.
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- BLOCK_W, 128, cache line width.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (highest index wins).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low.
- req_valid  in  NUM_PORTS  request pending, one bit per port.
- req_op  in  NUM_PORTS*2  operation: 0 LOAD_WORD, 1 LOAD_BLOCK, 2 STORE_WORD, 3 WB_REFILL.
- req_addr  in  NUM_PORTS*ADDR_W  load/store address, or refill address.
- req_wb_addr  in  NUM_PORTS*ADDR_W  victim writeback address (WB_REFILL only).
- req_wblock  in  NUM_PORTS*BLOCK_W  victim line.
- req_wword  in  NUM_PORTS*DATA_W  store word.
- req_wstrb  in  NUM_PORTS*(DATA_W/8)  store byte enables.
- req_cached  in  NUM_PORTS  cacheable attribute.
- req_accept  out  NUM_PORTS  one-cycle grant pulse.
- resp_valid  out  NUM_PORTS  one-cycle completion pulse.
- resp_rblock  out  BLOCK_W  refill data.
- resp_rword  out  DATA_W  uncached load data.
- axi_req  out  3  0 NONE, 1 LOAD_WORD, 2 LOAD_BLOCK, 3 WRITE_WORD, 4 WRITE_BLOCK.
- axi_addr  out  ADDR_W  bus address.
- axi_wblock  out  BLOCK_W  write line.
- axi_wword  out  DATA_W  write word.
- axi_wstrb  out  DATA_W/8  write strobes.
- axi_cached  out  1  cacheable attribute.
- axi_ready  in  1  bus adapter has taken the request.
- axi_finish  in  1  bus transaction complete; read data valid this cycle.
- axi_rblock  in  BLOCK_W  read line.
- axi_rword  in  DATA_W  read word.

Function
REQ-003 The block SHALL run a registered FSM with states IDLE, ISSUE, WAIT, WB_ISSUE, WB_WAIT and RESP.
REQ-004 In IDLE with any req_valid set, the block SHALL select a winner, pulse req_accept[winner] for one cycle, and latch the winner's op, addresses, data, strobes, cached bit and port index.
REQ-005 After latching, the next state SHALL be WB_ISSUE for op WB_REFILL and ISSUE for all other ops.
REQ-006 With RR_EN=1, the winner SHALL be the first valid port searched upward, with wrap, from last_grant+1; last_grant SHALL update only on a grant.
REQ-007 With RR_EN=0, the winner SHALL be the highest-index valid port.
REQ-008 axi_req, axi_addr, axi_wblock, axi_wword, axi_wstrb and axi_cached SHALL be registered and driven from the latched request only while in ISSUE or WB_ISSUE.
REQ-009 axi_req SHALL be NONE in every other state.
REQ-010 In WB_ISSUE, axi_req SHALL be WRITE_BLOCK with axi_addr = wb_addr; in ISSUE, axi_req SHALL be the op mapping and axi_addr = addr.
REQ-011 WB_REFILL SHALL map to LOAD_BLOCK in ISSUE.
REQ-012 In ISSUE or WB_ISSUE, the FSM SHALL hold until axi_ready=1, then move to WAIT or WB_WAIT respectively.
REQ-013 WB_WAIT SHALL go to ISSUE on axi_finish.
REQ-014 WAIT SHALL go to RESP on axi_finish and capture axi_rblock and axi_rword into resp_rblock and resp_rword.
REQ-015 RESP SHALL pulse resp_valid[port] for exactly one cycle and return to IDLE.
REQ-016 Minimum latency from accept to resp_valid SHALL be 3 cycles (ready and finish each asserted immediately).
REQ-017 No new grant SHALL occur before the RESP cycle; arbitration SHALL resume in the IDLE cycle that follows.
REQ-018 resp_rblock and resp_rword SHALL hold their values until the next capture.
REQ-019 axi_ready or axi_finish arriving in a state that does not wait for them SHALL be ignored.
REQ-020 A requester dropping req_valid after it has been accepted SHALL NOT abort the transaction.

Reset
REQ-021 When rstn=0 at a clock edge, the block SHALL enter IDLE, with last_grant = NUM_PORTS-1, axi_req = NONE, and req_accept, resp_valid, axi_addr, axi_wblock, axi_wword, axi_wstrb, axi_cached, resp_rblock and resp_rword all 0.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction with no resp_valid pulse.

Structure
REQ-023 The req_op and axi_req encodings and the FSM state enum SHALL live in the shared cache package, alongside the existing pipeline and response codes.
REQ-024 Arbitration SHALL be a sub-module, cache_rr_arbiter (parameters NUM_PORTS and RR_EN), taking valid and enable inputs and producing a one-hot grant plus its index.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single load: port 0 LOAD_BLOCK at addr 0x1C000040, axi_ready and axi_finish held high -> req_accept[0] at T, axi_req=LOAD_BLOCK with addr 0x1C000040 at T+1, resp_valid[0] at T+3 with resp_rblock equal to the driven axi_rblock.
- Writeback then refill: port 1 WB_REFILL with wb_addr 0x00001000 and addr 0x00002000 -> first WRITE_BLOCK to 0x1000 carrying wblock, then LOAD_BLOCK to 0x2000, exactly one resp_valid[1].
- Round-robin fairness: RR_EN=1, both ports valid continuously for 4 transactions -> grant order 0,1,0,1.
- Fixed priority: RR_EN=0, same stimulus -> all four grants go to port 1.
- Backpressure: axi_ready held low for 5 cycles in ISSUE -> axi_req and axi_addr stable for all 5 cycles, no resp_valid.
- Reset mid-WAIT: rstn low for 1 cycle -> IDLE, all outputs zero, no resp_valid, and a fresh request is accepted normally afterwards.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache package: memory request and bus encodings, the memory
// arbiter FSM states, and the pipeline/response codes used across the cache.
package cache_mem_arbiter_pkg;

  // Operation requested by an icache/dcache port.
  typedef enum logic [1:0] {
    OP_LOAD_WORD  = 2'd0,
    OP_LOAD_BLOCK = 2'd1,
    OP_STORE_WORD = 2'd2,
    OP_WB_REFILL  = 2'd3
  } req_op_e;

  // Request presented to the AXI bus adapter.
  typedef enum logic [2:0] {
    AXI_NONE        = 3'd0,
    AXI_LOAD_WORD   = 3'd1,
    AXI_LOAD_BLOCK  = 3'd2,
    AXI_WRITE_WORD  = 3'd3,
    AXI_WRITE_BLOCK = 3'd4
  } axi_req_e;

  // Memory arbiter FSM.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_WB_ISSUE = 3'd3,
    ST_WB_WAIT  = 3'd4,
    ST_RESP     = 3'd5
  } arb_state_e;

  // Pipeline control codes shared with the cache pipelines.
  typedef enum logic [1:0] {
    PIPE_RUN    = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_FLUSH  = 2'd2,
    PIPE_REPLAY = 2'd3
  } pipe_ctl_e;

  // Bus response codes.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_code_e;

  // Bus request for the final (non-writeback) phase of a cache operation.
  // A writeback-refill finishes with a line load.
  function automatic axi_req_e op_to_axi(input req_op_e op);
    op_to_axi = AXI_NONE;
    case (op)
      OP_LOAD_WORD:  op_to_axi = AXI_LOAD_WORD;
      OP_LOAD_BLOCK: op_to_axi = AXI_LOAD_BLOCK;
      OP_STORE_WORD: op_to_axi = AXI_WRITE_WORD;
      OP_WB_REFILL:  op_to_axi = AXI_LOAD_BLOCK;
      default:       op_to_axi = AXI_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the cache-side request/response signals and the AXI adapter
// signals of the memory arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the caches plus bus adapter around it.
interface cache_mem_arbiter_if
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BLOCK_W   = 128
) ();
  localparam int STRB_W = DATA_W / 8;

  // Cache requesters, flattened one slice per port.
  logic [NUM_PORTS-1:0]         req_valid;
  logic [NUM_PORTS*2-1:0]       req_op;
  logic [NUM_PORTS*ADDR_W-1:0]  req_addr;
  logic [NUM_PORTS*ADDR_W-1:0]  req_wb_addr;
  logic [NUM_PORTS*BLOCK_W-1:0] req_wblock;
  logic [NUM_PORTS*DATA_W-1:0]  req_wword;
  logic [NUM_PORTS*STRB_W-1:0]  req_wstrb;
  logic [NUM_PORTS-1:0]         req_cached;
  logic [NUM_PORTS-1:0]         req_accept;
  logic [NUM_PORTS-1:0]         resp_valid;
  logic [BLOCK_W-1:0]           resp_rblock;
  logic [DATA_W-1:0]            resp_rword;

  // AXI bus adapter.
  axi_req_e                     axi_req;
  logic [ADDR_W-1:0]            axi_addr;
  logic [BLOCK_W-1:0]           axi_wblock;
  logic [DATA_W-1:0]            axi_wword;
  logic [STRB_W-1:0]            axi_wstrb;
  logic                         axi_cached;
  logic                         axi_ready;
  logic                         axi_finish;
  logic [BLOCK_W-1:0]           axi_rblock;
  logic [DATA_W-1:0]            axi_rword;

  modport master (
    output req_valid, req_op, req_addr, req_wb_addr, req_wblock, req_wword,
           req_wstrb, req_cached,
    input  req_accept, resp_valid, resp_rblock, resp_rword,
    input  axi_req, axi_addr, axi_wblock, axi_wword, axi_wstrb, axi_cached,
    output axi_ready, axi_finish, axi_rblock, axi_rword
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wb_addr, req_wblock, req_wword,
           req_wstrb, req_cached,
    output req_accept, resp_valid, resp_rblock, resp_rword,
    output axi_req, axi_addr, axi_wblock, axi_wword, axi_wstrb, axi_cached,
    input  axi_ready, axi_finish, axi_rblock, axi_rword
  );

endinterface

// File: rtl/cache_mem_arbiter_arb.sv
// Requester arbiter: round-robin from the port after the last grant, or
// fixed priority with the highest index winning. Produces a one-hot grant
// (only while enabled) and the winner's index.
module cache_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter bit RR_EN     = 1'b1,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic             found;

  // Select the winner among the valid ports.
  always_comb begin
    int j;
    // NOTE: every output gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    if (RR_EN) begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        j = int'(last_grant) + i;
        if (j >= NUM_PORTS) j = j - NUM_PORTS;
        if (!found && valid[IDX_W'(j)]) begin
          found     = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end else begin
      // Later (higher) indices overwrite earlier ones.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (valid[IDX_W'(i)]) begin
          found     = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
    if (found && enable) grant[grant_idx] = 1'b1;
  end

  // Remember the most recent winner; it moves only when a grant is issued.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else if (|grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory arbiter between the icache/dcache ports and a single AXI bus
// adapter. One transaction at a time: accept, optional victim writeback,
// main bus access, then a one-cycle response pulse to the requester.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BLOCK_W   = 128,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  cache_mem_arbiter_if.slave   bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Request latched at accept time; the bus phases are driven from it.
  typedef struct packed {
    req_op_e            op;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  wb_addr;
    logic [BLOCK_W-1:0] wblock;
    logic [DATA_W-1:0]  wword;
    logic [STRB_W-1:0]  wstrb;
    logic               cached;
    logic [IDX_W-1:0]   port;
  } txn_t;

  arb_state_e           state, state_d;
  txn_t                 cur, cur_d, incoming;
  logic [NUM_PORTS-1:0] grant, resp_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 arb_en;

  // Arbitrate only in IDLE and never while reset is being applied.
  assign arb_en         = (state == ST_IDLE) && rstn;
  assign bus.req_accept = grant;

  cache_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .RR_EN     (RR_EN)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .valid     (bus.req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pull the winning port's fields out of the flattened request buses.
  always_comb begin
    incoming         = '0;
    incoming.op      = req_op_e'(bus.req_op[int'(grant_idx)*2 +: 2]);
    incoming.addr    = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    incoming.wb_addr = bus.req_wb_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    incoming.wblock  = bus.req_wblock[int'(grant_idx)*BLOCK_W +: BLOCK_W];
    incoming.wword   = bus.req_wword[int'(grant_idx)*DATA_W +: DATA_W];
    incoming.wstrb   = bus.req_wstrb[int'(grant_idx)*STRB_W +: STRB_W];
    incoming.cached  = bus.req_cached[grant_idx];
    incoming.port    = grant_idx;
  end

  // Next-state logic and request latching.
  always_comb begin
    state_d = state;
    cur_d   = cur;
    unique case (state)
      ST_IDLE: begin
        if (|grant) begin
          cur_d   = incoming;
          state_d = (incoming.op == OP_WB_REFILL) ? ST_WB_ISSUE : ST_ISSUE;
        end
      end
      ST_WB_ISSUE: if (bus.axi_ready)  state_d = ST_WB_WAIT;
      ST_WB_WAIT:  if (bus.axi_finish) state_d = ST_ISSUE;
      ST_ISSUE:    if (bus.axi_ready)  state_d = ST_WAIT;
      ST_WAIT:     if (bus.axi_finish) state_d = ST_RESP;
      ST_RESP:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // One-hot of the port that owns the transaction.
  always_comb begin
    resp_oh             = '0;
    resp_oh[cur_d.port] = 1'b1;
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
    end
  end

  // Registered bus outputs: live only in the issue states, quiet otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.axi_req    <= AXI_NONE;
      bus.axi_addr   <= '0;
      bus.axi_wblock <= '0;
      bus.axi_wword  <= '0;
      bus.axi_wstrb  <= '0;
      bus.axi_cached <= 1'b0;
    end else begin
      bus.axi_req    <= AXI_NONE;
      bus.axi_addr   <= '0;
      bus.axi_wblock <= '0;
      bus.axi_wword  <= '0;
      bus.axi_wstrb  <= '0;
      bus.axi_cached <= 1'b0;
      case (state_d)
        ST_WB_ISSUE: begin
          bus.axi_req    <= AXI_WRITE_BLOCK;
          bus.axi_addr   <= cur_d.wb_addr;
          bus.axi_wblock <= cur_d.wblock;
          bus.axi_cached <= cur_d.cached;
        end
        ST_ISSUE: begin
          bus.axi_req    <= op_to_axi(cur_d.op);
          bus.axi_addr   <= cur_d.addr;
          bus.axi_wblock <= cur_d.wblock;
          bus.axi_wword  <= cur_d.wword;
          bus.axi_wstrb  <= cur_d.wstrb;
          bus.axi_cached <= cur_d.cached;
        end
        default: ;
      endcase
    end
  end

  // Response pulse in RESP, and read data held from capture to capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.resp_valid  <= '0;
      bus.resp_rblock <= '0;
      bus.resp_rword  <= '0;
    end else begin
      bus.resp_valid <= (state_d == ST_RESP) ? resp_oh : '0;
      if (state == ST_WAIT && bus.axi_finish) begin
        bus.resp_rblock <= bus.axi_rblock;
        bus.resp_rword  <= bus.axi_rword;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a round-robin and a fixed-priority instance
// driven with identical stimulus and checked against a transaction model.
module tb_cache_mem_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 128;
  localparam int SW = DW / 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  // Per-port request fields and bus-side stimulus.
  logic [NP-1:0] vld;
  logic [1:0]    m_op   [NP];
  logic [AW-1:0] m_addr [NP];
  logic [AW-1:0] m_wb   [NP];
  logic [BW-1:0] m_wblk [NP];
  logic [DW-1:0] m_wwd  [NP];
  logic [SW-1:0] m_strb [NP];
  logic          m_cach [NP];
  logic          ardy, afin;
  logic [BW-1:0] rblk;
  logic [DW-1:0] rwd;

  logic [NP*2-1:0]  op_f;
  logic [NP*AW-1:0] addr_f, wb_f;
  logic [NP*BW-1:0] wblk_f;
  logic [NP*DW-1:0] wwd_f;
  logic [NP*SW-1:0] strb_f;
  logic [NP-1:0]    cach_f;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      op_f[p*2 +: 2]    = m_op[p];
      addr_f[p*AW +: AW] = m_addr[p];
      wb_f[p*AW +: AW]   = m_wb[p];
      wblk_f[p*BW +: BW] = m_wblk[p];
      wwd_f[p*DW +: DW]  = m_wwd[p];
      strb_f[p*SW +: SW] = m_strb[p];
      cach_f[p]          = m_cach[p];
    end
  end

  cache_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BLOCK_W(BW)) if_rr ();
  cache_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BLOCK_W(BW)) if_fp ();

  assign if_rr.req_valid = vld;     assign if_fp.req_valid = vld;
  assign if_rr.req_op = op_f;       assign if_fp.req_op = op_f;
  assign if_rr.req_addr = addr_f;   assign if_fp.req_addr = addr_f;
  assign if_rr.req_wb_addr = wb_f;  assign if_fp.req_wb_addr = wb_f;
  assign if_rr.req_wblock = wblk_f; assign if_fp.req_wblock = wblk_f;
  assign if_rr.req_wword = wwd_f;   assign if_fp.req_wword = wwd_f;
  assign if_rr.req_wstrb = strb_f;  assign if_fp.req_wstrb = strb_f;
  assign if_rr.req_cached = cach_f; assign if_fp.req_cached = cach_f;
  assign if_rr.axi_ready = ardy;    assign if_fp.axi_ready = ardy;
  assign if_rr.axi_finish = afin;   assign if_fp.axi_finish = afin;
  assign if_rr.axi_rblock = rblk;   assign if_fp.axi_rblock = rblk;
  assign if_rr.axi_rword = rwd;     assign if_fp.axi_rword = rwd;

  cache_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BLOCK_W(BW), .RR_EN(1'b1))
    dut_rr (.clk(clk), .rstn(rstn), .bus(if_rr));
  cache_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BLOCK_W(BW), .RR_EN(1'b0))
    dut_fp (.clk(clk), .rstn(rstn), .bus(if_fp));

  // Observed outputs, index 0 = round-robin instance, 1 = fixed priority.
  logic [NP-1:0] o_acc [2], o_rsp [2];
  logic [2:0]    o_req [2];
  logic [AW-1:0] o_addr[2];
  logic [BW-1:0] o_wblk[2], o_rblk[2];
  logic [DW-1:0] o_wwd [2], o_rwd [2];
  logic [SW-1:0] o_strb[2];
  logic          o_cach[2];

  assign o_acc[0] = if_rr.req_accept;  assign o_acc[1] = if_fp.req_accept;
  assign o_rsp[0] = if_rr.resp_valid;  assign o_rsp[1] = if_fp.resp_valid;
  assign o_req[0] = if_rr.axi_req;     assign o_req[1] = if_fp.axi_req;
  assign o_addr[0] = if_rr.axi_addr;   assign o_addr[1] = if_fp.axi_addr;
  assign o_wblk[0] = if_rr.axi_wblock; assign o_wblk[1] = if_fp.axi_wblock;
  assign o_wwd[0] = if_rr.axi_wword;   assign o_wwd[1] = if_fp.axi_wword;
  assign o_strb[0] = if_rr.axi_wstrb;  assign o_strb[1] = if_fp.axi_wstrb;
  assign o_cach[0] = if_rr.axi_cached; assign o_cach[1] = if_fp.axi_cached;
  assign o_rblk[0] = if_rr.resp_rblock; assign o_rblk[1] = if_fp.resp_rblock;
  assign o_rwd[0] = if_rr.resp_rword;  assign o_rwd[1] = if_fp.resp_rword;

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string scen    = "init";
  int    last_g [2];  // model: most recent winner per instance

  task automatic check(input string tag, input int d, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s dut=%s observed=%0h expected=%0h", scen, tag,
             (d == 0) ? "rr" : "fp", obs, exp);
    end
  endtask

  // Winner by the arbitration rules: round-robin from last winner + 1, or
  // the highest valid index.
  function automatic int model_winner(input int d, input logic [NP-1:0] v);
    if (d == 0) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (last_g[d] + k) % NP;
        if (v[p]) return p;
      end
    end else begin
      for (int p = NP - 1; p >= 0; p--) if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_bus_op(input logic [1:0] op);
    case (op)
      2'd0: return 3'd1;
      2'd1: return 3'd2;
      2'd2: return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_acc"}, d, o_acc[d], '0);
      check({tag, "_rsp"}, d, o_rsp[d], '0);
      check({tag, "_req"}, d, o_req[d], '0);
    end
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      check("acc", d, o_acc[d], '0);   check("rsp", d, o_rsp[d], '0);
      check("req", d, o_req[d], '0);   check("addr", d, o_addr[d], '0);
      check("wblk", d, o_wblk[d], '0); check("wwd", d, o_wwd[d], '0);
      check("strb", d, o_strb[d], '0); check("cach", d, o_cach[d], '0);
      check("rblk", d, o_rblk[d], '0); check("rwd", d, o_rwd[d], '0);
    end
  endtask

  // One full transaction from the IDLE cycle to the RESP cycle. The caller
  // loads m_* beforehand; vld is applied in the IDLE cycle. All ports that
  // may win share one op, so both instances follow the same timeline.
  task automatic run_txn(input logic [NP-1:0] mask, input int rdly, input int fdly,
                         input bit drop, output int w_rr, output int w_fp);
    int         w [2];
    int         nph;
    logic [2:0] ph_req  [2][2];
    logic [AW-1:0] ph_addr [2][2];
    logic [BW-1:0] eblk;
    logic [DW-1:0] ewd;
    @(negedge clk);
    vld = mask; ardy = 1'($urandom); afin = 1'($urandom);
    #1;
    for (int d = 0; d < 2; d++) begin
      w[d] = model_winner(d, mask);
      check("accept", d, o_acc[d], onehot(w[d]));
      check("idle_rsp", d, o_rsp[d], '0);
      check("idle_req", d, o_req[d], '0);
      last_g[d] = w[d];
      nph = (m_op[w[d]] == 2'd3) ? 2 : 1;
      ph_req[d][0]  = (nph == 2) ? 3'd4 : model_bus_op(m_op[w[d]]);
      ph_addr[d][0] = (nph == 2) ? m_wb[w[d]] : m_addr[w[d]];
      ph_req[d][1]  = model_bus_op(m_op[w[d]]);
      ph_addr[d][1] = m_addr[w[d]];
    end
    w_rr = w[0];
    w_fp = w[1];
    for (int i = 0; i < nph; i++) begin
      for (int k = 0; k <= rdly; k++) begin
        @(negedge clk);
        if (drop && i == 0 && k == 0) vld = '0;
        ardy = (k == rdly); afin = 1'($urandom);
        #1;
        for (int d = 0; d < 2; d++) begin
          check("axi_req", d, o_req[d], ph_req[d][i]);
          check("axi_addr", d, o_addr[d], ph_addr[d][i]);
          check("axi_cached", d, o_cach[d], m_cach[w[d]]);
          if (ph_req[d][i] == 3'd4) check("axi_wblock", d, o_wblk[d], m_wblk[w[d]]);
          if (ph_req[d][i] == 3'd3) begin
            check("axi_wword", d, o_wwd[d], m_wwd[w[d]]);
            check("axi_wstrb", d, o_strb[d], m_strb[w[d]]);
          end
          check("issue_rsp", d, o_rsp[d], '0);
          check("issue_acc", d, o_acc[d], '0);
        end
      end
      for (int k = 0; k <= fdly; k++) begin
        @(negedge clk);
        ardy = 1'($urandom); afin = (k == fdly);
        rblk = {$urandom, $urandom, $urandom, $urandom}; rwd = $urandom;
        #1;
        check_quiet("wait");
      end
    end
    eblk = rblk;
    ewd  = rwd;
    @(negedge clk);
    ardy = 1'($urandom); afin = 1'($urandom);
    rblk = {$urandom, $urandom, $urandom, $urandom}; rwd = $urandom;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("resp_valid", d, o_rsp[d], onehot(w[d]));
      check("resp_rblock", d, o_rblk[d], eblk);
      check("resp_rword", d, o_rwd[d], ewd);
      check("resp_acc", d, o_acc[d], '0);
      check("resp_req", d, o_req[d], '0);
    end
    vld = '0;
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [AW-1:0] wb);
    m_op[p] = op; m_addr[p] = a; m_wb[p] = wb;
    m_wblk[p] = {$urandom, $urandom, $urandom, $urandom};
    m_wwd[p] = $urandom; m_strb[p] = SW'($urandom); m_cach[p] = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int wr, wf;
    int exp_rr [4] = '{0, 1, 0, 1};
    vld = '0; ardy = 1'b0; afin = 1'b0; rblk = '0; rwd = '0;
    for (int p = 0; p < NP; p++) set_port(p, 2'd0, '0, '0);
    last_g[0] = NP - 1; last_g[1] = NP - 1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    scen = "reset";
    check_reset_state();

    scen = "single_load";
    set_port(0, 2'd1, 32'h1C00_0040, 32'h0);
    run_txn(2'b01, 0, 0, 1'b1, wr, wf);

    scen = "wb_refill";
    set_port(1, 2'd3, 32'h0000_2000, 32'h0000_1000);
    run_txn(2'b10, 0, 1, 1'b0, wr, wf);
    @(negedge clk); #1;
    check_quiet("after_wb");

    scen = "fairness";
    set_port(0, 2'd0, 32'hA000_0004, '0);
    set_port(1, 2'd0, 32'hB000_0008, '0);
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 0, 0, 1'b0, wr, wf);
      check("rr_order", 0, wr, exp_rr[i]);
      check("fp_order", 1, wf, 1);
    end

    scen = "backpressure";
    set_port(0, 2'd2, 32'h0000_0ABC, '0);
    run_txn(2'b01, 5, 0, 1'b0, wr, wf);

    scen = "reset_mid_wait";
    set_port(0, 2'd0, 32'h0000_0100, '0);
    @(negedge clk); vld = 2'b01; ardy = 1'b1; afin = 1'b0; #1;
    check("accept", 0, o_acc[0], 2'b01);
    check("accept", 1, o_acc[1], 2'b01);
    @(negedge clk); vld = '0; #1;
    check("issue_req", 0, o_req[0], 3'd1);
    check("issue_req", 1, o_req[1], 3'd1);
    @(negedge clk); rstn = 1'b0; afin = 1'b0; #1;
    check_quiet("wait");
    @(negedge clk); rstn = 1'b1; afin = 1'b1; ardy = 1'b1; #1;
    check_reset_state();
    last_g[0] = NP - 1; last_g[1] = NP - 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_quiet("post_reset");
    end
    set_port(1, 2'd1, 32'h0000_0200, '0);
    run_txn(2'b10, 1, 0, 1'b0, wr, wf);

    scen = "random";
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++) set_port(p, op, $urandom, $urandom);
      run_txn(NP'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), wr, wf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
